// File: rtl/issue_ctrl_if.sv
// Fetch-side, availability and issue-side signals of the instruction queue / issue scheduler.
// The slave modport is the issue_ctrl view; master is the surrounding pipeline.
interface issue_ctrl_if #(
    parameter int Q_WIDTH = 5
);
    logic               if_valid;
    logic [31:0]        if_instr;
    logic [31:0]        if_pc;
    logic               if_full;
    logic               rob_full;
    logic [Q_WIDTH-1:0] rob_free_tag;
    logic               rs_full;
    logic               slb_full;
    logic               issue_valid;
    logic [31:0]        issue_instr;
    logic [31:0]        issue_pc;
    logic [Q_WIDTH-1:0] issue_tag;
    logic               issue_to_rs;
    logic               issue_to_slb;

    modport slave (
        input  if_valid, if_instr, if_pc, rob_full, rob_free_tag, rs_full, slb_full,
        output if_full, issue_valid, issue_instr, issue_pc, issue_tag, issue_to_rs, issue_to_slb
    );

    modport master (
        output if_valid, if_instr, if_pc, rob_full, rob_free_tag, rs_full, slb_full,
        input  if_full, issue_valid, issue_instr, issue_pc, issue_tag, issue_to_rs, issue_to_slb
    );
endinterface

// File: rtl/issue_ctrl.sv
// Instruction queue plus in-order issue scheduler: buffers {instr, pc}, routes the head to RS or SLB
// when the ROB and target have room, silently drops illegal opcodes, and flushes on mispredict.
module issue_ctrl #(
    parameter int IQ_ADDR_WIDTH = 4,
    parameter int Q_WIDTH       = 5
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          clear_in,
    issue_ctrl_if.slave   bus
);
    localparam int DEPTH = 1 << IQ_ADDR_WIDTH;
    localparam logic [IQ_ADDR_WIDTH:0] DEPTH_CNT = DEPTH[IQ_ADDR_WIDTH:0];

    logic [31:0]              mem_instr [DEPTH];
    logic [31:0]              mem_pc    [DEPTH];
    logic [IQ_ADDR_WIDTH-1:0] head;
    logic [IQ_ADDR_WIDTH-1:0] tail;
    logic [IQ_ADDR_WIDTH:0]   count;

    logic [31:0] head_instr;
    logic        to_slb;
    logic        to_rs;
    logic        can_issue;
    logic        drop_illegal;
    logic        push_en;
    logic        pop_en;

    assign head_instr = mem_instr[head];
    assign bus.if_full = (count == DEPTH_CNT);

    always_comb begin
        to_slb = 1'b0;
        to_rs  = 1'b0;
        case (head_instr[6:0])
            7'b0000011, 7'b0100011: to_slb = 1'b1;
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0010011, 7'b0110011: to_rs = 1'b1;
            default: ;
        endcase
    end

    // Illegal heads leave the queue regardless of ROB/RS/SLB backpressure.
    assign can_issue    = (count != '0) && !bus.rob_full &&
                          ((to_rs && !bus.rs_full) || (to_slb && !bus.slb_full));
    assign drop_illegal = (count != '0) && !to_rs && !to_slb;
    assign pop_en       = can_issue || drop_illegal;
    assign push_en      = bus.if_valid && (count != DEPTH_CNT);

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !clear_in && push_en) begin
            mem_instr[tail] <= bus.if_instr;
            mem_pc[tail]    <= bus.if_pc;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            bus.issue_valid  <= 1'b0;
            bus.issue_instr  <= '0;
            bus.issue_pc     <= '0;
            bus.issue_tag    <= '0;
            bus.issue_to_rs  <= 1'b0;
            bus.issue_to_slb <= 1'b0;
        end else if (!rdy_in) begin
            bus.issue_valid <= 1'b0;
        end else if (clear_in) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            bus.issue_valid <= 1'b0;
        end else begin
            if (push_en) tail <= tail + 1'b1;
            if (pop_en)  head <= head + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            bus.issue_valid <= can_issue;
            if (can_issue) begin
                bus.issue_instr  <= head_instr;
                bus.issue_pc     <= mem_pc[head];
                bus.issue_tag    <= bus.rob_free_tag;
                bus.issue_to_rs  <= to_rs;
                bus.issue_to_slb <= to_slb;
            end
        end
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl.
module tb_issue_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clear;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] LW   = 32'h0000A083;
    localparam logic [31:0] ILL  = 32'h0000007F;

    issue_ctrl_if #(.Q_WIDTH(5)) bus ();

    issue_ctrl #(.IQ_ADDR_WIDTH(4), .Q_WIDTH(5)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .rdy_in   (rdy),
        .clear_in (clear),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        bus.if_valid = v;
        bus.if_instr = instr;
        bus.if_pc    = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({bus.issue_valid, bus.issue_to_rs, bus.issue_to_slb, bus.if_full} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000",
                     {bus.issue_valid, bus.issue_to_rs, bus.issue_to_slb, bus.if_full});
        else pass_cnt++;
        total_cnt++;
        if ({bus.issue_instr, bus.issue_pc, bus.issue_tag} !== 69'd0)
            $display("FAIL reset_fields instr=%h pc=%h tag=%0d want 0",
                     bus.issue_instr, bus.issue_pc, bus.issue_tag);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_single_issue();
        bus.rob_free_tag = 5'd7;
        set_push(1'b1, ADDI, 32'h0);
        tick();
        set_push(1'b0, '0, '0);
        total_cnt++;
        if (bus.issue_valid !== 1'b0) $display("FAIL single_no_bypass got %b want 0", bus.issue_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.issue_valid, bus.issue_to_rs, bus.issue_to_slb} !== 3'b110 || bus.issue_pc !== 32'h0 ||
            bus.issue_tag !== 5'd7 || bus.issue_instr !== ADDI)
            $display("FAIL single_issue v/rs/slb=%b pc=%h tag=%0d instr=%h want 110 0 7 %h",
                     {bus.issue_valid, bus.issue_to_rs, bus.issue_to_slb}, bus.issue_pc,
                     bus.issue_tag, bus.issue_instr, ADDI);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.issue_valid !== 1'b0 || bus.issue_tag !== 5'd7)
            $display("FAIL single_pulse_end valid=%b tag=%0d want 0 7", bus.issue_valid, bus.issue_tag);
        else pass_cnt++;
    endtask

    task automatic test_slb_block();
        bus.slb_full = 1'b1;
        bus.rob_free_tag = 5'd3;
        set_push(1'b1, LW, 32'h100);
        tick();
        set_push(1'b1, ADD, 32'h104);
        for (int i = 0; i < 3; i++) begin
            tick();
            set_push(1'b0, '0, '0);
            total_cnt++;
            if (bus.issue_valid !== 1'b0) $display("FAIL slb_blocked cycle %0d got %b want 0", i, bus.issue_valid);
            else pass_cnt++;
        end
        bus.slb_full = 1'b0;
        tick();
        total_cnt++;
        if ({bus.issue_valid, bus.issue_to_rs, bus.issue_to_slb} !== 3'b101 || bus.issue_pc !== 32'h100 ||
            bus.issue_tag !== 5'd3)
            $display("FAIL slb_issue v/rs/slb=%b pc=%h tag=%0d want 101 100 3",
                     {bus.issue_valid, bus.issue_to_rs, bus.issue_to_slb}, bus.issue_pc, bus.issue_tag);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.issue_valid, bus.issue_to_rs, bus.issue_to_slb} !== 3'b110 || bus.issue_pc !== 32'h104)
            $display("FAIL slb_follower v/rs/slb=%b pc=%h want 110 104",
                     {bus.issue_valid, bus.issue_to_rs, bus.issue_to_slb}, bus.issue_pc);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_full();
        bus.rob_full = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_push(1'b1, ADDI, 32'(i * 4));
            tick();
            total_cnt++;
            if (bus.if_full !== (i == 15)) $display("FAIL full_flag push %0d got %b want %b", i, bus.if_full, i == 15);
            else pass_cnt++;
        end
        set_push(1'b1, ADD, 32'h40);
        tick();
        set_push(1'b0, '0, '0);
        total_cnt++;
        if (bus.if_full !== 1'b1 || bus.issue_valid !== 1'b0)
            $display("FAIL full_overflow full=%b valid=%b want 1 0", bus.if_full, bus.issue_valid);
        else pass_cnt++;
        bus.rob_full = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            total_cnt++;
            if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 32'(i * 4))
                $display("FAIL full_drain %0d valid=%b pc=%h want 1 %h", i, bus.issue_valid, bus.issue_pc, 32'(i * 4));
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (bus.issue_valid !== 1'b0 || bus.if_full !== 1'b0)
            $display("FAIL full_dropped_17th valid=%b full=%b want 0 0", bus.issue_valid, bus.if_full);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= 40; i++) begin
            set_push(1'b1, ADDI, 32'h1000 + 32'(i * 4));
            tick();
            total_cnt++;
            if (dut.count !== 5'd1) $display("FAIL b2b_count %0d got %0d want 1", i, dut.count);
            else pass_cnt++;
            if (i >= 1) begin
                total_cnt++;
                if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 32'h1000 + 32'((i - 1) * 4))
                    $display("FAIL b2b_issue %0d valid=%b pc=%h want 1 %h", i, bus.issue_valid,
                             bus.issue_pc, 32'h1000 + 32'((i - 1) * 4));
                else pass_cnt++;
            end
        end
        set_push(1'b0, '0, '0);
        tick();
        total_cnt++;
        if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 32'h10A0)
            $display("FAIL b2b_last valid=%b pc=%h want 1 10a0", bus.issue_valid, bus.issue_pc);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_clear();
        bus.rob_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_push(1'b1, ADDI, 32'h200 + 32'(i * 4));
            tick();
        end
        set_push(1'b1, ADD, 32'h2F0);
        bus.rob_full = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        set_push(1'b0, '0, '0);
        total_cnt++;
        if (bus.issue_valid !== 1'b0 || dut.count !== 5'd0)
            $display("FAIL clear valid=%b count=%0d want 0 0", bus.issue_valid, dut.count);
        else pass_cnt++;
        set_push(1'b1, ADDI, 32'h300);
        tick();
        set_push(1'b0, '0, '0);
        total_cnt++;
        if (bus.issue_valid !== 1'b0) $display("FAIL clear_after_push got %b want 0", bus.issue_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 32'h300)
            $display("FAIL clear_reissue valid=%b pc=%h want 1 300", bus.issue_valid, bus.issue_pc);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_illegal();
        set_push(1'b1, ILL, 32'h400);
        tick();
        set_push(1'b1, ADDI, 32'h404);
        tick();
        set_push(1'b0, '0, '0);
        total_cnt++;
        if (bus.issue_valid !== 1'b0) $display("FAIL illegal_dropped got %b want 0", bus.issue_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 32'h404)
            $display("FAIL illegal_next valid=%b pc=%h want 1 404", bus.issue_valid, bus.issue_pc);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_rdy_hold();
        set_push(1'b1, ADDI, 32'h600);
        rdy = 1'b0;
        tick();
        tick();
        set_push(1'b0, '0, '0);
        total_cnt++;
        if (bus.issue_valid !== 1'b0 || dut.count !== 5'd0 || bus.issue_pc !== 32'h404)
            $display("FAIL rdy_hold valid=%b count=%0d pc=%h want 0 0 404", bus.issue_valid, dut.count, bus.issue_pc);
        else pass_cnt++;
        rdy = 1'b1;
        set_push(1'b1, ADDI, 32'h608);
        tick();
        set_push(1'b0, '0, '0);
        rdy = 1'b0;
        tick();
        total_cnt++;
        if (bus.issue_valid !== 1'b0 || dut.count !== 5'd1)
            $display("FAIL rdy_stall valid=%b count=%0d want 0 1", bus.issue_valid, dut.count);
        else pass_cnt++;
        rdy = 1'b1;
        tick();
        total_cnt++;
        if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 32'h608)
            $display("FAIL rdy_resume valid=%b pc=%h want 1 608", bus.issue_valid, bus.issue_pc);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.rob_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, ADDI, 32'h700 + 32'(i * 4));
            tick();
        end
        set_push(1'b0, '0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.rob_full = 1'b0;
        total_cnt++;
        if (dut.count !== 5'd0 || bus.issue_pc !== 32'h0)
            $display("FAIL reset_mid count=%0d pc=%h want 0 0", dut.count, bus.issue_pc);
        else pass_cnt++;
        set_push(1'b1, ADDI, 32'h500);
        tick();
        set_push(1'b0, '0, '0);
        tick();
        total_cnt++;
        if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 32'h500)
            $display("FAIL reset_mid_first valid=%b pc=%h want 1 500", bus.issue_valid, bus.issue_pc);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        clear = 1'b0;
        bus.rob_full = 1'b0;
        bus.rs_full = 1'b0;
        bus.slb_full = 1'b0;
        bus.rob_free_tag = '0;
        set_push(1'b0, '0, '0);
        test_reset();
        test_single_issue();
        test_slb_block();
        test_full();
        test_back_to_back();
        test_clear();
        test_illegal();
        test_rdy_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
